stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Parametrised 1-to-N_CH stream demultiplexer with valid/ready handshake and packet-locked channel select.
- Registered single-beat output stage, so one beat in, one beat out, at full throughput.
- Used wherever one upstream stream fans out to N_CH downstream consumers.
- Replaces fixed-width combinational 1-to-4 demux usage where back-pressure and packet framing are needed.

Parameters:
- DATA_W, 8, payload width per beat.
- N_CH, 4, number of output channels; range 2..16.
- SEL_W, $clog2(N_CH), select width; derived, do not override.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  upstream ready.
- s_data  input  DATA_W  upstream payload.
- s_sel  input  SEL_W  destination channel; sampled on the first beat of a packet only.
- s_last  input  1  marks the final beat of a packet.
- m_valid  output  N_CH  per-channel valid; at most one bit set.
- m_ready  input  N_CH  per-channel ready.
- m_data  output  DATA_W  payload shared by all channels; qualified by m_valid.
- m_last  output  1  last flag for the beat currently presented.
- busy  output  1  high while in LOCK or DROP.

Behaviour:
- Reset values (clk edge with rst=1): m_valid=0, m_data=0, m_last=0, busy=0, FSM=IDLE, held channel=0. Reset mid-packet discards any held beat and the lock.
- Transfer definitions: an upstream transfer is s_valid & s_ready. A downstream transfer is m_valid[c] & m_ready[c].
- s_ready = !out_full | m_ready[out_ch]. In DROP, s_ready=1.
- Output register: an accepted beat appears on m_data/m_last with m_valid[ch] set on the next cycle, giving a latency of 1. Beats are held stable until the downstream transfer completes. Simultaneous drain and fill in one cycle is allowed, giving 1 beat/cycle.
- FSM states:
  - IDLE: on an upstream transfer with s_sel<N_CH, latch ch=s_sel and load the output register. Next state is LOCK, or stays IDLE if s_last.
  - IDLE, invalid select: on an upstream transfer with s_sel>=N_CH, discard the beat. Next state is DROP, or stays IDLE if s_last.
  - LOCK: s_sel is ignored and beats route to the latched ch. An upstream transfer with s_last returns to IDLE.
  - DROP: beats are accepted and discarded, and no m_valid is raised. An upstream transfer with s_last returns to IDLE.
- Back-to-back packets: a new packet's first beat is accepted in the cycle after the previous last beat. Its s_sel may differ; the beat is queued behind the held beat with no bubble required.
- Invalid select when N_CH is a power of two: cannot occur; DROP logic is optimised away.
- m_valid is one-hot or zero. Data on non-selected channels carries no meaning.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- With the macro defined, the block adds output drop_cnt [15:0]:
  - increments once per packet that enters DROP, counted at the first beat;
  - saturates at 16'hFFFF;
  - clears on rst.
- Without the macro, the port and counter are absent and dropped packets are silent.

Decomposition:
- Package stream_demux_pkg holds:
  - FSM state enum (IDLE, LOCK, DROP);
  - constant DROP_CNT_W=16;
  - a function computing the one-hot from a select and channel count.
- Sub-module demux_out_reg holds the single-beat output register (data, last, channel, full) and its load/drain logic. The FSM stays in stream_demux.

Test Plan:
- Reset, then a 3-beat packet with s_sel=2, data 0x11,0x22,0x33, all m_ready=1 -> m_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after the first accept; m_last only on 0x33.
- Mid-packet select change: s_sel=1 on beat 1, then s_sel=3 on beats 2-3 -> all beats on channel 1.
- Back-pressure: m_ready[0]=0 for 5 cycles during a packet to ch0 -> s_ready=0 after one beat held; m_data stable; no beat lost or duplicated once m_ready[0]=1.
- Back-to-back packets: 1-beat packet to ch0, then 1-beat packet to ch3, with no idle cycle on s_valid -> m_valid 4'b0001 then 4'b1000 in consecutive cycles.
- Invalid select with N_CH=3: 2-beat packet with s_sel=3 -> s_ready=1 throughout, m_valid=0, busy=1 for one cycle; drop_cnt=1 when STREAM_DEMUX_DROP_CNT_EN is defined.
- Reset mid-packet: assert rst while a beat is held in LOCK -> next cycle m_valid=0 and busy=0; the following packet's s_sel is honoured.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared FSM state type, drop counter width and one-hot helper.
package stream_demux_pkg;
    typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;
    localparam int DROP_CNT_W = 16;
    function automatic logic [15:0] onehot(input logic [3:0] sel, input int n);
        logic [15:0] r;
        r = '0;
        if (int'(sel) < n) r[sel] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: upstream and per-channel downstream stream signals of the demux.
// slave modport is the demux view, master modport is the driver/consumer view.
interface stream_demux_if #(parameter int DATA_W = 8, parameter int N_CH = 4);
    localparam int SEL_W = $clog2(N_CH);
    logic s_valid, s_ready, s_last, m_last;
    logic [DATA_W-1:0] s_data, m_data;
    logic [SEL_W-1:0] s_sel;
    logic [N_CH-1:0] m_valid, m_ready;
    modport slave(input s_valid, s_data, s_sel, s_last, m_ready, output s_ready, m_valid, m_data, m_last);
    modport master(output s_valid, s_data, s_sel, s_last, m_ready, input s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/stream_demux_out_reg.sv
// demux_out_reg: single-beat output register with per-channel valid and drain/fill in one cycle.
// load/d_* fill the register; m_* present the held beat; space is high when a beat can be loaded.
module demux_out_reg import stream_demux_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int N_CH = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    input  logic [SEL_W-1:0]  d_ch,
    input  logic [N_CH-1:0]   m_ready,
    output logic [N_CH-1:0]   m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              space
);
    logic full;
    logic [SEL_W-1:0] ch;
    assign space = !full || m_ready[ch];
    assign m_valid = full ? N_CH'(onehot(4'(ch), N_CH)) : '0;
    always_ff @(posedge clk)
        if (rst) begin
            full <= 1'b0;
            ch <= '0;
            m_data <= '0;
            m_last <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            ch <= d_ch;
            m_data <= d_data;
            m_last <= d_last;
        end else if (space) full <= 1'b0;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N_CH stream demux, channel locked per packet, registered output stage.
// Ports: clk, rst (sync, active high), bus (stream_demux_if.slave), busy (LOCK or DROP),
// drop_cnt (only with STREAM_DEMUX_DROP_CNT_EN defined: saturating count of dropped packets).
module stream_demux import stream_demux_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int N_CH = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic clk,
    input  logic rst,
    stream_demux_if.slave bus,
    output logic busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    state_t state, nxt;
    logic [SEL_W-1:0] lock_ch;
    logic sel_ok, space, up, load;
    // constant-true for power-of-two N_CH, so the DROP path folds away
    assign sel_ok = int'(bus.s_sel) < N_CH;
    assign bus.s_ready = state == DROP || space;
    assign up = bus.s_valid && bus.s_ready;
    assign busy = state != IDLE;
    always_comb begin
        nxt = state;
        load = up && (state == LOCK || (state == IDLE && sel_ok));
        if (up) nxt = bus.s_last ? IDLE : state == IDLE ? (sel_ok ? LOCK : DROP) : state;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            lock_ch <= '0;
        end else begin
            state <= nxt;
            if (up && state == IDLE) lock_ch <= bus.s_sel;
        end
    demux_out_reg #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) u_out (
        .clk(clk),
        .rst(rst),
        .load(load),
        .d_data(bus.s_data),
        .d_last(bus.s_last),
        .d_ch(state == IDLE ? bus.s_sel : lock_ch),
        .m_ready(bus.m_ready),
        .m_valid(bus.m_valid),
        .m_data(bus.m_data),
        .m_last(bus.m_last),
        .space(space)
    );
`ifdef STREAM_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk)
        if (rst) drop_cnt <= '0;
        else if (up && state == IDLE && !sel_ok && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: random and directed stimulus on a 4- and a 3-channel demux against a queue model.
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst, s_valid, s_last, sel3;
    logic [7:0] s_data;
    logic [1:0] s_sel;
    logic [3:0] m_ready;
    logic busy4, busy3;
    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_CH(4)) b4();
    stream_demux_if #(.DATA_W(8), .N_CH(3)) b3();
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] dc4, dc3, drop_o;
    stream_demux #(.DATA_W(8), .N_CH(4)) u4(.clk(clk), .rst(rst), .bus(b4), .busy(busy4), .drop_cnt(dc4));
    stream_demux #(.DATA_W(8), .N_CH(3)) u3(.clk(clk), .rst(rst), .bus(b3), .busy(busy3), .drop_cnt(dc3));
    assign drop_o = sel3 ? dc3 : dc4;
`else
    stream_demux #(.DATA_W(8), .N_CH(4)) u4(.clk(clk), .rst(rst), .bus(b4), .busy(busy4));
    stream_demux #(.DATA_W(8), .N_CH(3)) u3(.clk(clk), .rst(rst), .bus(b3), .busy(busy3));
`endif

    assign b4.s_valid = s_valid;
    assign b4.s_data = s_data;
    assign b4.s_sel = s_sel;
    assign b4.s_last = s_last;
    assign b4.m_ready = m_ready;
    assign b3.s_valid = s_valid;
    assign b3.s_data = s_data;
    assign b3.s_sel = s_sel;
    assign b3.s_last = s_last;
    assign b3.m_ready = m_ready[2:0];

    logic s_ready_o, m_last_o, busy_o;
    logic [3:0] m_valid_o;
    logic [7:0] m_data_o;
    assign s_ready_o = sel3 ? b3.s_ready : b4.s_ready;
    assign m_valid_o = sel3 ? {1'b0, b3.m_valid} : b4.m_valid;
    assign m_data_o = sel3 ? b3.m_data : b4.m_data;
    assign m_last_o = sel3 ? b3.m_last : b4.m_last;
    assign busy_o = sel3 ? busy3 : busy4;

    typedef struct {int ch; logic [7:0] d; logic l;} beat_t;
    beat_t q[$];
    int n = 4, pkt = -2, drops = 0, tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // pkt: -2 between packets, -1 dropping, else the channel the packet is locked to
    task automatic tick(output bit acc);
        bit held, rdy;
        int c;
        #1;
        held = q.size() != 0;
        rdy = pkt == -1 || !held || m_ready[q[0].ch];
        chk("s_ready", 32'(s_ready_o), 32'(rdy));
        acc = s_valid && rdy && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            pkt = -2;
            drops = 0;
        end else begin
            if (held && m_ready[q[0].ch]) void'(q.pop_front());
            if (acc) begin
                c = pkt != -2 ? pkt : int'(s_sel) < n ? int'(s_sel) : -1;
                if (pkt == -2 && c < 0 && drops < 65535) drops++;
                if (c >= 0) q.push_back('{c, s_data, s_last});
                pkt = s_last ? -2 : c;
            end
        end
        #1;
        chk("m_valid", 32'(m_valid_o), q.size() != 0 ? 32'(1 << q[0].ch) : 32'(0));
        if (q.size() != 0) begin
            chk("m_data", 32'(m_data_o), 32'(q[0].d));
            chk("m_last", 32'(m_last_o), 32'(q[0].l));
        end
        chk("busy", 32'(busy_o), 32'(pkt != -2));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_o), 32'(drops));
`endif
    endtask

    task automatic beat(input logic [1:0] sel, input logic [7:0] d, input logic l);
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_sel = sel;
        s_data = d;
        s_last = l;
        for (int i = 0; i < 20; i++) begin
            tick(acc);
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 32'(0), 32'(1));
        s_valid = 1'b0;
    endtask

    task automatic do_reset(input bit to3);
        bit acc;
        rst = 1'b1;
        s_valid = 1'b0;
        tick(acc);
        rst = 1'b0;
        sel3 = to3;
        n = to3 ? 3 : 4;
    endtask

    initial begin
        bit acc;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_sel = '0;
        s_last = 1'b0;
        m_ready = 4'hF;
        sel3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mvalid4", 32'(b4.m_valid), 32'(0));
        chk("rst_mdata4", 32'(b4.m_data), 32'(0));
        chk("rst_mlast4", 32'(b4.m_last), 32'(0));
        chk("rst_busy4", 32'(busy4), 32'(0));
        chk("rst_mvalid3", 32'(b3.m_valid), 32'(0));
        chk("rst_busy3", 32'(busy3), 32'(0));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("rst_dropcnt", 32'(dc3), 32'(0));
`endif
        rst = 1'b0;

        beat(2, 8'h11, 1'b0);
        chk("p1_mv0", 32'(m_valid_o), 32'(4'b0100));
        chk("p1_last0", 32'(m_last_o), 32'(0));
        beat(2, 8'h22, 1'b0);
        chk("p1_mv1", 32'(m_valid_o), 32'(4'b0100));
        chk("p1_last1", 32'(m_last_o), 32'(0));
        beat(2, 8'h33, 1'b1);
        chk("p1_mv2", 32'(m_valid_o), 32'(4'b0100));
        chk("p1_data2", 32'(m_data_o), 32'(8'h33));
        chk("p1_last2", 32'(m_last_o), 32'(1));
        tick(acc);
        chk("p1_idle", 32'(m_valid_o), 32'(0));

        beat(1, 8'hA1, 1'b0);
        chk("lock_mv0", 32'(m_valid_o), 32'(4'b0010));
        beat(3, 8'hA2, 1'b0);
        chk("lock_mv1", 32'(m_valid_o), 32'(4'b0010));
        beat(3, 8'hA3, 1'b1);
        chk("lock_mv2", 32'(m_valid_o), 32'(4'b0010));

        m_ready = 4'hE;
        beat(0, 8'hB1, 1'b0);
        chk("bp_first", 32'(m_valid_o), 32'(4'b0001));
        s_valid = 1'b1;
        s_sel = 2'd0;
        s_data = 8'hB2;
        s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("bp_stall", 32'(acc), 32'(0));
            chk("bp_hold", 32'(m_data_o), 32'(8'hB1));
        end
        m_ready = 4'hF;
        tick(acc);
        chk("bp_resume", 32'(acc), 32'(1));
        chk("bp_data", 32'(m_data_o), 32'(8'hB2));
        beat(0, 8'hB3, 1'b1);
        chk("bp_data3", 32'(m_data_o), 32'(8'hB3));

        beat(0, 8'hC0, 1'b1);
        chk("b2b_ch0", 32'(m_valid_o), 32'(4'b0001));
        beat(3, 8'hC3, 1'b1);
        chk("b2b_ch3", 32'(m_valid_o), 32'(4'b1000));
        tick(acc);

        do_reset(1'b1);
        beat(3, 8'hD1, 1'b0);
        chk("drop_busy1", 32'(busy_o), 32'(1));
        chk("drop_mv1", 32'(m_valid_o), 32'(0));
        beat(3, 8'hD2, 1'b1);
        chk("drop_busy2", 32'(busy_o), 32'(0));
        chk("drop_mv2", 32'(m_valid_o), 32'(0));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("drop_cnt1", 32'(drop_o), 32'(1));
`endif

        do_reset(1'b0);
        m_ready = 4'h0;
        beat(1, 8'hE1, 1'b0);
        chk("mid_held", 32'(m_valid_o), 32'(4'b0010));
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        chk("mid_mv", 32'(m_valid_o), 32'(0));
        chk("mid_busy", 32'(busy_o), 32'(0));
        m_ready = 4'hF;
        beat(2, 8'hE2, 1'b1);
        chk("mid_newsel", 32'(m_valid_o), 32'(4'b0100));

        for (int d = 0; d < 2; d++) begin
            do_reset(d == 1);
            for (int i = 0; i < 400; i++) begin
                s_valid = $urandom_range(0, 9) < 7;
                s_data = 8'($urandom);
                s_sel = 2'($urandom);
                s_last = $urandom_range(0, 2) == 0;
                m_ready = 4'($urandom) | 4'($urandom);
                rst = $urandom_range(0, 99) == 0;
                tick(acc);
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
